// File: rtl/fx3_tx_bridge.sv
// Vector buffer and FX3 slave-FIFO write bridge: queues 23-bit vectors from the
// vector generator and streams them to the FX3 as sequence-tagged 32-bit words.
module fx3_tx_bridge #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        ena,
    input  logic        intr,
    input  logic [22:0] data_in,
    output logic        ack,
    input  logic        flush,
    input  logic        fx3_full_n,
    output logic        fx3_slwr_n,
    output logic        fx3_pktend_n,
    output logic [31:0] fx3_data,
    output logic [4:0]  level
);

    // state     | meaning
    // ----------+-------------------------------------------------------
    // IDLE      | nothing to send, or FX3 full before a burst started
    // WRITE     | one buffered word per cycle onto the FX3 bus
    // WAIT_FULL | FX3 reported full mid-burst, strobe held off
    // PKTEND    | single-cycle packet-end strobe for a pending flush
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_WAIT_FULL = 2'd2;
    localparam logic [1:0] S_PKTEND    = 2'd3;

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [22:0]   mem [DEPTH];
    logic [7:0]    seq;
    logic          flush_pend;
    logic          pkt_dirty;

    logic          buf_empty;
    logic          accept;
    logic          pop;
    logic          flush_ok;
    logic          flush_drop;
    logic          start_pkt;
    logic          flush_clr;

    always_comb begin
        buf_empty  = (level == 5'd0);
        accept     = intr & ena & ~ack & (level < DEPTH_L);
        pop        = ena & fx3_full_n & ~buf_empty & (state == S_WRITE);
        // A flush only means something once everything queued has gone out
        // and there is at least one word in the current packet.
        flush_ok   = flush_pend & buf_empty & pkt_dirty & fx3_full_n;
        flush_drop = flush_pend & buf_empty & ~(pkt_dirty & fx3_full_n);
    end

    always_comb begin
        state_nxt = state;
        start_pkt = 1'b0;
        flush_clr = 1'b0;
        if (!ena) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!buf_empty && fx3_full_n) begin
                        state_nxt = S_WRITE;
                    end else if (flush_ok) begin
                        state_nxt = S_PKTEND;
                        start_pkt = 1'b1;
                    end else begin
                        flush_clr = flush_drop;
                    end
                end
                S_WRITE: begin
                    if (!fx3_full_n) begin
                        state_nxt = S_WAIT_FULL;
                    end else if (buf_empty) begin
                        if (flush_ok) begin
                            state_nxt = S_PKTEND;
                            start_pkt = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                            flush_clr = flush_drop;
                        end
                    end
                end
                S_WAIT_FULL: begin
                    if (fx3_full_n) begin
                        state_nxt = buf_empty ? S_IDLE : S_WRITE;
                    end
                end
                S_PKTEND: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state        <= S_IDLE;
            ack          <= 1'b0;
            fx3_slwr_n   <= 1'b1;
            fx3_pktend_n <= 1'b1;
            fx3_data     <= 32'd0;
            level        <= 5'd0;
            seq          <= 8'd0;
            flush_pend   <= 1'b0;
            pkt_dirty    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state        <= state_nxt;
            ack          <= accept;
            level        <= level + 5'(accept) - 5'(pop);
            fx3_slwr_n   <= ~pop;
            fx3_pktend_n <= ~start_pkt;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                fx3_data  <= {seq, 1'b0, mem[rd_ptr]};
                seq       <= seq + 8'd1;
                pkt_dirty <= 1'b1;
            end else if (start_pkt) begin
                pkt_dirty <= 1'b0;
            end
            // A new flush request wins over clearing the old one.
            flush_pend <= flush | (flush_pend & ~start_pkt & ~flush_clr);
        end
    end

    // Payload storage needs no reset; level and the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_fx3_tx_bridge.sv
// Directed bench for fx3_tx_bridge: a cycle-accurate vector table followed by
// hand-written back-pressure, full-stall, flush, wrap and reset sequences.
module tb_fx3_tx_bridge;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        ena = 1'b0;
    logic        intr = 1'b0;
    logic [22:0] data_in = 23'd0;
    logic        flush = 1'b0;
    logic        fx3_full_n = 1'b1;
    logic        ack;
    logic        fx3_slwr_n;
    logic        fx3_pktend_n;
    logic [31:0] fx3_data;
    logic [4:0]  level;

    int          n_tests = 0;
    int          n_fail = 0;
    int          pk_cnt = 0;
    logic [31:0] wq[$];

    typedef struct {
        logic        ena;
        logic        intr;
        logic [22:0] d;
        logic        full_n;
        logic        flush;
        logic        ack;
        logic        slwr_n;
        logic        pktend_n;
        logic [4:0]  lvl;
        logic [31:0] data;
    } vec_t;

    vec_t vt[19];

    always #5 clk = ~clk;

    fx3_tx_bridge #(.DEPTH(8)) dut (
        .clk          (clk),
        .arst         (arst),
        .ena          (ena),
        .intr         (intr),
        .data_in      (data_in),
        .ack          (ack),
        .flush        (flush),
        .fx3_full_n   (fx3_full_n),
        .fx3_slwr_n   (fx3_slwr_n),
        .fx3_pktend_n (fx3_pktend_n),
        .fx3_data     (fx3_data),
        .level        (level)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arst) begin
            if (!fx3_slwr_n) wq.push_back(fx3_data);
            if (!fx3_pktend_n) begin
                pk_cnt++;
                check("pktend_without_slwr", {63'd0, fx3_slwr_n}, 64'd1);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        arst = 1'b0;
        intr = 1'b0;
        flush = 1'b0;
        data_in = 23'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
        tick();
        wq.delete();
        pk_cnt = 0;
    endtask

    task automatic send(input logic [22:0] d);
        int n;
        n = 0;
        intr = 1'b1;
        data_in = d;
        do begin
            tick();
            n++;
        end while (!ack && n < 20);
        check("send_ack", {63'd0, ack}, 64'd1);
        intr = 1'b0;
    endtask

    task automatic wait_words(input int k, input string name);
        int n;
        n = 0;
        while (wq.size() < k && n < 2000) begin
            tick();
            n++;
        end
        check(name, 64'(wq.size()), 64'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  cnt;
        int  bad;
        logic got_ack;
        logic [22:0] d;

        ena = 1'b1;
        fx3_full_n = 1'b1;
        do_reset();
        check("reset_state", {24'd0, ack, fx3_slwr_n, fx3_pktend_n, level, fx3_data},
              {24'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0});

        //       ena  intr d            full flush ack  slwr pkt  lvl   data
        vt[0]  = '{1'b1, 1'b1, 23'h12345, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_0000};
        vt[1]  = '{1'b1, 1'b1, 23'h12345, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0000_0000};
        vt[2]  = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0001_2345};
        vt[3]  = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0001_2345};
        vt[4]  = '{1'b1, 1'b1, 23'h00ABC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0001_2345};
        vt[5]  = '{1'b1, 1'b1, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0001_2345};
        vt[6]  = '{1'b1, 1'b1, 23'h7FFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0100_0ABC};
        vt[7]  = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h027F_FFFF};
        vt[8]  = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h027F_FFFF};
        vt[9]  = '{1'b0, 1'b1, 23'h00001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h027F_FFFF};
        vt[10] = '{1'b1, 1'b1, 23'h00001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h027F_FFFF};
        vt[11] = '{1'b0, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h027F_FFFF};
        vt[12] = '{1'b0, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h027F_FFFF};
        vt[13] = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h027F_FFFF};
        vt[14] = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0300_0001};
        vt[15] = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0300_0001};
        vt[16] = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0300_0001};
        vt[17] = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0300_0001};
        vt[18] = '{1'b1, 1'b0, 23'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0300_0001};

        for (int i = 0; i < 19; i++) begin
            ena = vt[i].ena;
            intr = vt[i].intr;
            data_in = vt[i].d;
            fx3_full_n = vt[i].full_n;
            flush = vt[i].flush;
            tick();
            check($sformatf("row%0d", i),
                  {24'd0, ack, fx3_slwr_n, fx3_pktend_n, level, fx3_data},
                  {24'd0, vt[i].ack, vt[i].slwr_n, vt[i].pktend_n, vt[i].lvl, vt[i].data});
        end
        intr = 1'b0;
        flush = 1'b0;
        ena = 1'b1;

        // back-pressure: 8 fit, the 9th waits until the FX3 drains the buffer
        fx3_full_n = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) send(23'h100 + 23'(i));
        check("bp_level8", 64'(level), 64'd8);
        intr = 1'b1;
        data_in = 23'h108;
        got_ack = 1'b0;
        repeat (10) begin
            tick();
            if (ack) got_ack = 1'b1;
        end
        check("bp_9th_unacked", {63'd0, got_ack}, 64'd0);
        check("bp_level_hold", 64'(level), 64'd8);
        fx3_full_n = 1'b1;
        n = 0;
        while (!ack && n < 40) begin
            tick();
            n++;
        end
        check("bp_9th_ack", {63'd0, ack}, 64'd1);
        intr = 1'b0;
        wait_words(9, "bp_word_count");
        for (int i = 0; i < 9; i++)
            if (i < wq.size())
                check($sformatf("bp_word%0d", i), 64'(wq[i]), 64'({8'(i), 1'b0, 23'h100 + 23'(i)}));

        // FX3 goes full after three words of a six-word burst
        fx3_full_n = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) send(23'h200 + 23'(i));
        fx3_full_n = 1'b1;
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 40) begin
            tick();
            n++;
            if (!fx3_slwr_n) cnt++;
        end
        fx3_full_n = 1'b0;
        repeat (6) tick();
        check("stall_words_before", 64'(wq.size()), 64'd3);
        check("stall_level", 64'(level), 64'd3);
        fx3_full_n = 1'b1;
        wait_words(6, "stall_word_count");
        for (int i = 0; i < 6; i++)
            if (i < wq.size())
                check($sformatf("stall_word%0d", i), 64'(wq[i]), 64'({8'(i), 1'b0, 23'h200 + 23'(i)}));
        repeat (3) tick();
        check("stall_no_dup", 64'(wq.size()), 64'd6);

        // flush after two words, then again with nothing new written
        do_reset();
        send(23'h300);
        send(23'h301);
        wait_words(2, "flush_words");
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        check("flush_pktend_once", 64'(pk_cnt), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        check("flush_empty_no_pktend", 64'(pk_cnt), 64'd1);

        // 257 words: sequence tag wraps back to zero on the last one
        do_reset();
        for (int i = 0; i < 257; i++) send(23'(i) ^ 23'h2A5A5);
        wait_words(257, "wrap_word_count");
        bad = 0;
        for (int i = 0; i < 257 && i < wq.size(); i++) begin
            d = 23'(i) ^ 23'h2A5A5;
            if (wq[i] !== {8'(i), 1'b0, d}) bad++;
        end
        check("wrap_all_words", 64'(bad), 64'd0);
        if (wq.size() >= 257) begin
            check("wrap_seq255", 64'(wq[255][31:24]), 64'd255);
            check("wrap_seq0", 64'(wq[256][31:24]), 64'd0);
        end

        // asynchronous reset while the buffer holds five vectors
        fx3_full_n = 1'b0;
        for (int i = 0; i < 5; i++) send(23'h400 + 23'(i));
        check("rst_level5", 64'(level), 64'd5);
        fx3_full_n = 1'b1;
        n = 0;
        while (fx3_slwr_n && n < 20) begin
            tick();
            n++;
        end
        check("rst_strobe_active", {63'd0, fx3_slwr_n}, 64'd0);
        #3;
        arst = 1'b0;
        #1;
        check("async_reset", {24'd0, ack, fx3_slwr_n, fx3_pktend_n, level, fx3_data},
              {24'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0});
        @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
        wq.delete();
        tick();
        check("post_release_no_strobe", {58'd0, fx3_slwr_n, level}, {58'd0, 1'b1, 5'd0});
        repeat (4) tick();
        check("post_release_discarded", 64'(wq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
